pwm_dac_tx: RTL

PWM transmitter: converts an 8-bit code into a pulse-width-modulated output whose duty cycle is proportional to the code. The output drives the board RC filter that forms the DAC reference for the comparator front end, which makes this block the transmit end of the duty-cycle measurement path. New codes arrive over a valid/ready handshake and are applied only at period boundaries, so the output never carries a truncated pulse. A `settled` flag tells the downstream comparator logic when the filtered voltage has had time to settle.

---
 rtl/pwm_dac_pkg.sv | 20 ++
 rtl/pwm_period_counter.sv | 28 ++
 rtl/pwm_dac_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared types and helpers for the PWM DAC transmitter.
package pwm_dac_pkg;

  localparam int unsigned CODE_W = 8;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    SETTLING = 2'd1,
    SETTLED  = 2'd2
  } pwm_state_t;

  // Scale an 8-bit code up to an n-bit compare threshold (n >= CODE_W, n <= 32).
  function automatic logic [31:0] dac_threshold(input logic [CODE_W-1:0] code,
                                                input int unsigned n);
    logic [31:0] wide;
    wide = {{(32 - CODE_W){1'b0}}, code};
    return wide << (n - CODE_W);
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter; held at zero while cleared.
module pwm_period_counter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         run,
  output logic [N-1:0] cnt,
  output logic         wrap,
  output logic         at_zero
);

  logic [N-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  assign cnt     = cnt_q;
  assign wrap    = run && (cnt_q == '1);
  assign at_zero = run && (cnt_q == '0);

endmodule

// File: rtl/pwm_dac_tx.sv
// PWM DAC transmitter: handshake-fed duty code, applied only at period boundaries,
// with a settle flag for the downstream comparator.
module pwm_dac_tx
  import pwm_dac_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned SETTLE_PERIODS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              pwm_out,
  output logic              period_start,
  output logic [CODE_W-1:0] active_code,
  output logic              settled
);

  localparam logic [7:0] SettleMax = 8'(SETTLE_PERIODS);

  pwm_state_t        state_q, state_d;
  logic [CODE_W-1:0] active_q, active_d;
  logic [CODE_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [7:0]        settle_q, settle_d;
  logic              pwm_q, pwm_d;
  logic              ps_q, ps_d;

  logic              running;
  logic              accept;
  logic              wrap;
  logic              at_zero;
  logic              code_change;
  logic [N-1:0]      cnt;
  logic [31:0]       thr;

  assign running = enable && (state_q != DISABLED);
  assign accept  = code_valid && !pend_full_q;
  assign thr     = dac_threshold(active_q, N);

  pwm_period_counter #(
    .N (N)
  ) u_period_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (!running),
    .run     (running),
    .cnt     (cnt),
    .wrap    (wrap),
    .at_zero (at_zero)
  );

  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (!running) begin
      // No period in flight, so nothing can be truncated: load straight away.
      if (accept) begin
        active_d = code_in;
      end
    end else if (wrap) begin
      if (pend_full_q) begin
        active_d    = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        active_d = code_in;
      end
    end else if (accept) begin
      pend_d      = code_in;
      pend_full_d = 1'b1;
    end
  end

  assign code_change = (active_d != active_q);

  always_comb begin
    settle_d = settle_q;
    if (!running || code_change) begin
      settle_d = '0;
    end else if (wrap && (settle_q != SettleMax)) begin
      settle_d = settle_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = DISABLED;
    end else begin
      unique case (state_q)
        DISABLED: state_d = SETTLING;
        SETTLING: if (settle_d == SettleMax) state_d = SETTLED;
        SETTLED:  if (code_change) state_d = SETTLING;
        default:  state_d = DISABLED;
      endcase
    end
  end

  assign pwm_d = running && (32'(cnt) < thr);
  assign ps_d  = at_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DISABLED;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      settle_q    <= '0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      settle_q    <= settle_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign code_ready   = !pend_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign active_code  = active_q;
  assign settled      = (state_q == SETTLED);

endmodule
